// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
//   Shared types and constants for the rv32i memory stage.
//   - XLEN          : datapath / address width
//   - word_t        : XLEN-wide data word
//   - LOAD_*        : funct3 encodings of the integer load instructions
//   - load_state_e  : state encoding of the load engine
//   - load_misaligned() : natural-alignment test for a load request
// -----------------------------------------------------------------------------
package rv32i_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam logic [2:0] LOAD_LB  = 3'd0;
  localparam logic [2:0] LOAD_LH  = 3'd1;
  localparam logic [2:0] LOAD_LW  = 3'd2;
  localparam logic [2:0] LOAD_LBU = 3'd4;
  localparam logic [2:0] LOAD_LHU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } load_state_e;

  // Halfwords must sit on an even byte, words on lane 0. Encodings that are
  // not a defined byte/half load behave as a word load.
  function automatic logic load_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
    logic result;
    case (funct3)
      LOAD_LB, LOAD_LBU: result = 1'b0;
      LOAD_LH, LOAD_LHU: result = offset[0];
      default:           result = (offset != 2'b00);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
//   Combinational lane select and sign/zero extension of a read word.
//   Kept separate so a store-to-load forwarding path can reuse it.
// Ports:
//   i_rdata   in  XLEN  raw word from the data bus
//   i_offset  in  2     byte offset of the load (address bits [1:0])
//   i_funct3  in  3     load type (LB/LH/LW/LBU/LHU; others act as LW)
//   o_data    out XLEN  aligned and extended result
// -----------------------------------------------------------------------------
module load_extend
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // A halfword only looks at offset bit 1, so an odd offset folds down to
  // the enclosing even halfword.
  assign w_byte = i_rdata[8*i_offset +: 8];
  assign w_half = i_rdata[16*i_offset[1] +: 16];

  always_comb begin
    case (i_funct3)
      LOAD_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      LOAD_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
      LOAD_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
      LOAD_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
      default:  o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
//   Memory-stage load engine. Accepts one decoded load, issues a word-aligned
//   read on the data bus, waits for the response and returns the aligned,
//   extended value to write-back as a one-cycle valid pulse.
//
// Build option:
//   LOAD_MISALIGN_TRAP_EN  when defined, misaligned LH/LHU/LW requests skip
//                          the bus and return o_load_err=1 one cycle after
//                          acceptance. When undefined, low address bits below
//                          natural alignment are ignored.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   i_req_valid     load request from execute
//   o_req_ready     unit is idle and can accept a request
//   i_req_addr      effective byte address
//   i_req_funct3    load type
//   o_dbus_arvalid  read address valid
//   i_dbus_arready  read address accepted
//   o_dbus_araddr   word-aligned read address
//   i_dbus_rvalid   read data valid
//   o_dbus_rready   unit accepts read data (RESP only)
//   i_dbus_rdata    read word
//   i_dbus_rerr     bus error, qualified by rvalid
//   o_load_valid    one-cycle result pulse
//   o_load_data     extended result, held between pulses
//   o_load_err      bus/alignment error, qualified by o_load_valid
// -----------------------------------------------------------------------------
module load_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [2:0]      i_req_funct3,
  output logic            o_dbus_arvalid,
  input  logic            i_dbus_arready,
  output logic [XLEN-1:0] o_dbus_araddr,
  input  logic            i_dbus_rvalid,
  output logic            o_dbus_rready,
  input  logic [XLEN-1:0] i_dbus_rdata,
  input  logic            i_dbus_rerr,
  output logic            o_load_valid,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_load_err
);

  load_state_e     r_state;
  logic            r_arvalid;
  logic [XLEN-1:0] r_araddr;
  logic [1:0]      r_offset;
  logic [2:0]      r_funct3;
  logic            r_load_valid;
  logic [XLEN-1:0] r_load_data;
  logic            r_load_err;

  load_state_e     w_state_nxt;
  logic            w_arvalid_nxt;
  logic [XLEN-1:0] w_araddr_nxt;
  logic [1:0]      w_offset_nxt;
  logic [2:0]      w_funct3_nxt;
  logic            w_load_valid_nxt;
  logic [XLEN-1:0] w_load_data_nxt;
  logic            w_load_err_nxt;
  logic [XLEN-1:0] w_extended;
  logic            w_misalign;

`ifdef LOAD_MISALIGN_TRAP_EN
  assign w_misalign = load_misaligned(i_req_funct3, i_req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // Extension works on the captured offset/type, since the request inputs
  // are only valid in the acceptance cycle.
  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .i_rdata  (i_dbus_rdata),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_data   (w_extended)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_arvalid_nxt    = r_arvalid;
    w_araddr_nxt     = r_araddr;
    w_offset_nxt     = r_offset;
    w_funct3_nxt     = r_funct3;
    w_load_valid_nxt = 1'b0;
    w_load_data_nxt  = r_load_data;
    w_load_err_nxt   = r_load_err;
    o_req_ready      = 1'b0;
    o_dbus_rready    = 1'b0;

    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_offset_nxt = i_req_addr[1:0];
          w_funct3_nxt = i_req_funct3;
          if (w_misalign) begin
            // Trap without touching the bus; the pulse lands next cycle and
            // the unit is already idle again for the following request.
            w_load_valid_nxt = 1'b1;
            w_load_err_nxt   = 1'b1;
            w_load_data_nxt  = '0;
          end else begin
            w_araddr_nxt  = {i_req_addr[XLEN-1:2], 2'b00};
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = ADDR;
          end
        end
      end

      ADDR: begin
        if (i_dbus_arready) begin
          w_arvalid_nxt = 1'b0;
          w_state_nxt   = RESP;
        end
      end

      RESP: begin
        o_dbus_rready = 1'b1;
        if (i_dbus_rvalid) begin
          w_load_valid_nxt = 1'b1;
          w_load_err_nxt   = i_dbus_rerr;
          w_load_data_nxt  = i_dbus_rerr ? '0 : w_extended;
          w_state_nxt      = IDLE;
        end
      end

      default: begin
        w_arvalid_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_offset     <= 2'b00;
      r_funct3     <= LOAD_LW;
      r_load_valid <= 1'b0;
      r_load_data  <= '0;
      r_load_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_araddr     <= w_araddr_nxt;
      r_offset     <= w_offset_nxt;
      r_funct3     <= w_funct3_nxt;
      r_load_valid <= w_load_valid_nxt;
      r_load_data  <= w_load_data_nxt;
      r_load_err   <= w_load_err_nxt;
    end
  end

  assign o_dbus_arvalid = r_arvalid;
  assign o_dbus_araddr  = r_araddr;
  assign o_load_valid   = r_load_valid;
  assign o_load_data    = r_load_data;
  assign o_load_err     = r_load_err;

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Memory-stage load engine of the rv32i core, directly upstream of write-back.
- Accepts one decoded load (effective address plus funct3) and issues a word-aligned read on the data bus.
- Waits for the bus response, then aligns and sign- or zero-extends the returned lane.
- Presents the result to write-back as a single-cycle valid pulse with registered data; write-back stalls its pipeline until that pulse arrives.

Parameters:
- XLEN, 32, datapath and address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- i_req_valid  in  1  load request from execute.
- o_req_ready  out  1  unit can accept a request (state IDLE).
- i_req_addr  in  XLEN  effective byte address.
- i_req_funct3  in  3  load type: LB=0, LH=1, LW=2, LBU=4, LHU=5.
- o_dbus_arvalid  out  1  read address valid.
- i_dbus_arready  in  1  read address accepted.
- o_dbus_araddr  out  XLEN  word-aligned address, bits [1:0]=0.
- i_dbus_rvalid  in  1  read data valid.
- o_dbus_rready  out  1  unit accepts read data.
- i_dbus_rdata  in  XLEN  read word.
- i_dbus_rerr  in  1  bus error flag, qualified by rvalid.
- o_load_valid  out  1  one-cycle result pulse to write-back.
- o_load_data  out  XLEN  extended load result.
- o_load_err  out  1  bus or alignment error, qualified by o_load_valid.

Behaviour:
- Reset values: o_load_valid=0, o_load_err=0, o_load_data=0, o_dbus_arvalid=0, o_dbus_araddr=0, state=IDLE.
- Reset mid-operation drops arvalid immediately. The data bus shares rst, so no response is drained.
- FSM states: IDLE, ADDR, RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, capture addr[1:0] and funct3, drive araddr={addr[XLEN-1:2],2'b0}, set arvalid, go to ADDR.
- ADDR:
  - arvalid held with araddr stable until i_dbus_arready.
  - On the handshake, clear arvalid and go to RESP.
- RESP:
  - o_dbus_rready=1.
  - On i_dbus_rvalid, register the extended data into o_load_data, pulse o_load_valid for exactly one cycle, set o_load_err=i_dbus_rerr, go to IDLE.
- o_dbus_rready=0 outside RESP. rvalid outside RESP is ignored.
- Minimum latency: accept at cycle N, arvalid at N+1 (arready same cycle), rvalid at N+2, o_load_valid at N+3.
- Back-to-back: a new request may be accepted in the cycle o_load_valid is high, because the state is IDLE then.
- o_load_data holds its value between pulses.
- Lane select:
  - Byte = rdata[8*addr[1:0] +: 8].
  - Half = rdata[16*addr[1] +: 16].
  - Word = rdata.
- Extension: LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
- Undefined funct3 (3, 6, 7) is treated as LW.
- On a bus error, o_load_data=0.

Optional Feature:
- Macro: LOAD_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned request: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - Such a request issues no bus access.
  - The unit goes IDLE→RESP-equivalent and pulses o_load_valid one cycle after acceptance, with o_load_err=1 and o_load_data=0.
- Undefined:
  - Low address bits below natural alignment are ignored; a halfword uses addr[1] only, a word uses lane 0.
  - No error is raised for misalignment.

Decomposition:
- rv32i_pkg:
  - funct3 localparams LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU.
  - typedef enum load_state_e {IDLE, ADDR, RESP}.
  - typedef logic [XLEN-1:0] word_t.
- Sub-module load_extend (combinational):
  - Inputs: rdata, offset[1:0], funct3.
  - Output: extended word.
  - Reusable by a future store-to-load forwarding path.

Test Plan:
- LB at 0x1003, rdata=0x80FF_1234, arready/rvalid immediate → araddr=0x1000, o_load_data=0xFFFF_FF80, o_load_valid at N+3 for one cycle.
- LHU at 0x2002, rdata=0xBEEF_0001 → o_load_data=0x0000_BEEF; LH on the same data → 0xFFFF_BEEF.
- LW at 0x3000, arready delayed 3 cycles, rvalid delayed 4 more → arvalid/araddr stable throughout, o_req_ready=0 until the pulse, single o_load_valid with 0x3000 data.
- Back-to-back LW 0x10 then LW 0x14, the second i_req_valid held → second request accepted in the pulse cycle of the first, two pulses with the correct data in order.
- rst asserted in RESP while waiting for rvalid → next cycle state IDLE, o_req_ready=1, arvalid=0, no o_load_valid.
- LW at 0x4002 with LOAD_MISALIGN_TRAP_EN defined → no arvalid, o_load_valid and o_load_err=1, data=0. Without the macro → araddr=0x4000, normal load, o_load_err=0.
